serial_operand_loader: RTL and testbench

Sequencer that sits around the 4-bit ripple-carry adder. It shifts two 4-bit operands in over a single serial line and drives them, plus carry-in, onto the adder inputs. It waits for the ripple chain to settle, captures {c_out, s} into a result register, and holds it under a valid/ack handshake. This gives the combinational adder a clocked, bit-serial front end and a registered back end.

---
 rtl/serial_operand_loader_if.sv | 42 ++++
 rtl/serial_operand_loader.sv | 158 +++++++++++++++
 tb/tb_serial_operand_loader.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_operand_loader_if.sv
// serial_operand_loader_if
// Bundles the loader's handshake and data signals in one interface.
//   Requester side : start, c_in_req, ser_in, ser_valid -> loader; ser_ready, busy <- loader
//   Adder side     : x, y, c_in -> adder; s, c_out -> loader
//   Consumer side  : result, result_valid <- loader; result_ack -> loader
// Optional: SIGNED_OVF_EN adds the ovf signal (two's-complement overflow flag).
// Modports: slave = the loader itself, master = everything around it.
interface serial_operand_loader_if;
  logic       start;
  logic       c_in_req;
  logic       ser_in;
  logic       ser_valid;
  logic       ser_ready;
  logic [3:0] x;
  logic [3:0] y;
  logic       c_in;
  logic [3:0] s;
  logic       c_out;
  logic [4:0] result;
  logic       result_valid;
  logic       result_ack;
  logic       busy;
`ifdef SIGNED_OVF_EN
  logic       ovf;
`endif

  modport slave (
    input  start, c_in_req, ser_in, ser_valid, s, c_out, result_ack,
    output ser_ready, x, y, c_in, result, result_valid, busy
`ifdef SIGNED_OVF_EN
    , output ovf
`endif
  );

  modport master (
    output start, c_in_req, ser_in, ser_valid, s, c_out, result_ack,
    input  ser_ready, x, y, c_in, result, result_valid, busy
`ifdef SIGNED_OVF_EN
    , input ovf
`endif
  );
endinterface

// File: rtl/serial_operand_loader.sv
// serial_operand_loader
// Bit-serial front end and registered back end for a 4-bit ripple-carry adder.
// Two 4-bit operands are shifted in over ser_in/ser_valid and driven onto the
// adder as registered x/y/c_in. After SETTLE_CYCLES cycles the adder output
// {c_out, s} is captured into result and held under a result_valid/result_ack
// handshake.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_operand_loader_if.slave (start, c_in_req, ser_in, ser_valid,
//           ser_ready, x, y, c_in, s, c_out, result, result_valid, result_ack,
//           busy, and ovf when SIGNED_OVF_EN is defined)
// Parameters:
//   SETTLE_CYCLES : cycles spent waiting for the ripple chain (1..15)
//   LSB_FIRST     : 1 = operand bits arrive LSB first, 0 = MSB first
// Optional feature macro: SIGNED_OVF_EN (adds the registered ovf output).
module serial_operand_loader #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          LSB_FIRST     = 1'b1
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_operand_loader_if.slave bus
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_Y,
    SETTLE,
    HOLD
  } state_t;

  state_t     state_q;
  logic [3:0] x_q;
  logic [3:0] y_q;
  logic       cIn_q;
  logic [4:0] result_q;
  logic       resultValid_q;
  logic       serReady_q;
  logic       busy_q;
  logic [1:0] bitCnt_q;
  logic [3:0] settleCnt_q;
`ifdef SIGNED_OVF_EN
  logic       ovf_q;
`endif

  logic [3:0] xShift_d;
  logic [3:0] yShift_d;
  logic       lastBit_d;

  // Shift-register next values for the configured bit order, and detection of
  // the edge that accepts the fourth bit of the operand currently loading.
  always_comb begin
    xShift_d  = x_q;
    yShift_d  = y_q;
    if (LSB_FIRST) begin
      xShift_d = {bus.ser_in, x_q[3:1]};
      yShift_d = {bus.ser_in, y_q[3:1]};
    end else begin
      xShift_d = {x_q[2:0], bus.ser_in};
      yShift_d = {y_q[2:0], bus.ser_in};
    end
    lastBit_d = bus.ser_valid && (bitCnt_q == 2'd3);
  end

  // Sequencer. All outputs are registered here so the adder sees glitch-free
  // operands and the consumer sees a stable result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      x_q           <= 4'd0;
      y_q           <= 4'd0;
      cIn_q         <= 1'b0;
      result_q      <= 5'd0;
      resultValid_q <= 1'b0;
      serReady_q    <= 1'b0;
      busy_q        <= 1'b0;
      bitCnt_q      <= 2'd0;
      settleCnt_q   <= 4'd0;
`ifdef SIGNED_OVF_EN
      ovf_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            cIn_q      <= bus.c_in_req;
            x_q        <= 4'd0;
            y_q        <= 4'd0;
            bitCnt_q   <= 2'd0;
            busy_q     <= 1'b1;
            serReady_q <= 1'b1;
            state_q    <= LOAD_X;
          end
        end
        LOAD_X: begin
          if (bus.ser_valid) begin
            x_q      <= xShift_d;
            bitCnt_q <= bitCnt_q + 2'd1;
            if (lastBit_d) begin
              bitCnt_q <= 2'd0;
              state_q  <= LOAD_Y;
            end
          end
        end
        LOAD_Y: begin
          if (bus.ser_valid) begin
            y_q      <= yShift_d;
            bitCnt_q <= bitCnt_q + 2'd1;
            if (lastBit_d) begin
              bitCnt_q    <= 2'd0;
              settleCnt_q <= SETTLE_LOAD;
              serReady_q  <= 1'b0;
              state_q     <= SETTLE;
            end
          end
        end
        SETTLE: begin
          // Counter value 1 marks the exit edge; <= also guards a zero load.
          if (settleCnt_q <= 4'd1) begin
            result_q      <= {bus.c_out, bus.s};
            resultValid_q <= 1'b1;
`ifdef SIGNED_OVF_EN
            ovf_q         <= (x_q[3] == y_q[3]) && (bus.s[3] != x_q[3]);
`endif
            state_q       <= HOLD;
          end else begin
            settleCnt_q <= settleCnt_q - 4'd1;
          end
        end
        HOLD: begin
          // result (and ovf) deliberately survive the ack.
          if (bus.result_ack) begin
            resultValid_q <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.x            = x_q;
  assign bus.y            = y_q;
  assign bus.c_in         = cIn_q;
  assign bus.result       = result_q;
  assign bus.result_valid = resultValid_q;
  assign bus.ser_ready    = serReady_q;
  assign bus.busy         = busy_q;
`ifdef SIGNED_OVF_EN
  assign bus.ovf          = ovf_q;
`endif

endmodule

// File: tb/tb_serial_operand_loader.sv
// tb_serial_operand_loader
// Drives two loader instances from one shared serial stream:
//   dutA : LSB_FIRST=1, SETTLE_CYCLES=1
//   dutB : LSB_FIRST=0, SETTLE_CYCLES=3
// Each instance sees an ideal adder built from plain arithmetic. Expected
// operands, sums, latencies and flags come from a reference model that
// rebuilds the operands from the arrival order of the serial bits.
module tb_serial_operand_loader;

  logic clk = 1'b0;
  logic rst_n;
  logic start, cInReq, serIn, serValid, resultAck;
  int   testCount = 0;
  int   failCount = 0;

  always #5 clk = ~clk;

  serial_operand_loader_if ifA ();
  serial_operand_loader_if ifB ();

  assign ifA.start      = start;
  assign ifA.c_in_req   = cInReq;
  assign ifA.ser_in     = serIn;
  assign ifA.ser_valid  = serValid;
  assign ifA.result_ack = resultAck;
  assign ifB.start      = start;
  assign ifB.c_in_req   = cInReq;
  assign ifB.ser_in     = serIn;
  assign ifB.ser_valid  = serValid;
  assign ifB.result_ack = resultAck;

  // Ideal adders.
  assign {ifA.c_out, ifA.s} = 5'(ifA.x) + 5'(ifA.y) + 5'(ifA.c_in);
  assign {ifB.c_out, ifB.s} = 5'(ifB.x) + 5'(ifB.y) + 5'(ifB.c_in);

  serial_operand_loader #(.SETTLE_CYCLES(1), .LSB_FIRST(1'b1)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(ifA.slave)
  );
  serial_operand_loader #(.SETTLE_CYCLES(3), .LSB_FIRST(1'b0)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(ifB.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Both instances idle with nothing pending.
  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busyA"}, 32'(ifA.busy), 32'd0);
    checkOutput({tag, "_busyB"}, 32'(ifB.busy), 32'd0);
    checkOutput({tag, "_validA"}, 32'(ifA.result_valid), 32'd0);
    checkOutput({tag, "_validB"}, 32'(ifB.result_valid), 32'd0);
    checkOutput({tag, "_readyA"}, 32'(ifA.ser_ready), 32'd0);
    checkOutput({tag, "_readyB"}, 32'(ifB.ser_ready), 32'd0);
  endtask

  // xSeq/ySeq: bit i is the i-th bit sent on the serial line.
  task automatic applyStimulus(input logic cin, input logic [3:0] xSeq,
                               input logic [3:0] ySeq, input bit stall,
                               input bit ackWithStart);
    int   xA, yA, xB, yB, sumA, sumB, latA, latB;
    logic bitVal;
    bit   ovfA, ovfB;
    xA = 0; yA = 0; xB = 0; yB = 0;

    @(posedge clk); #1;
    start = 1'b1; cInReq = cin;
    @(posedge clk); #1;
    start = 1'b0; cInReq = 1'($urandom);
    checkOutput("busyA_load", 32'(ifA.busy), 32'd1);
    checkOutput("readyB_load", 32'(ifB.ser_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      bitVal = (i < 4) ? xSeq[i] : ySeq[i - 4];
      if (i < 4) begin
        xA = xA + (int'(bitVal) << i);
        xB = xB * 2 + int'(bitVal);
      end else begin
        yA = yA + (int'(bitVal) << (i - 4));
        yB = yB * 2 + int'(bitVal);
      end
      // Stalls also wiggle start/ack, which must be ignored mid-transaction.
      if (stall) begin
        repeat ($urandom_range(0, 2)) begin
          serValid = 1'b0; serIn = 1'($urandom);
          start = 1'($urandom); resultAck = 1'($urandom);
          @(posedge clk); #1;
        end
      end
      serValid = 1'b1; serIn = bitVal; start = 1'b0; resultAck = 1'b0;
      @(posedge clk); #1;
    end
    serValid = 1'b0;

    checkOutput("validA_early", 32'(ifA.result_valid), 32'd0);
    checkOutput("validB_early", 32'(ifB.result_valid), 32'd0);
    checkOutput("readyA_settle", 32'(ifA.ser_ready), 32'd0);

    sumA = xA + yA + int'(cin);
    sumB = xB + yB + int'(cin);
    latA = 0; latB = 0;
    for (int k = 1; k <= 20 && (latA == 0 || latB == 0); k++) begin
      @(posedge clk); #1;
      if (latA == 0 && ifA.result_valid) latA = k;
      if (latB == 0 && ifB.result_valid) latB = k;
    end
    checkOutput("latencyA", 32'(latA), 32'd1);
    checkOutput("latencyB", 32'(latB), 32'd3);
    checkOutput("xA", 32'(ifA.x), 32'(xA));
    checkOutput("yA", 32'(ifA.y), 32'(yA));
    checkOutput("xB", 32'(ifB.x), 32'(xB));
    checkOutput("yB", 32'(ifB.y), 32'(yB));
    checkOutput("cinA", 32'(ifA.c_in), 32'(cin));
    checkOutput("resultA", 32'(ifA.result), 32'(sumA));
    checkOutput("resultB", 32'(ifB.result), 32'(sumB));
    ovfA = (xA[3] == yA[3]) && (sumA[3] != xA[3]);
    ovfB = (xB[3] == yB[3]) && (sumB[3] != xB[3]);
`ifdef SIGNED_OVF_EN
    checkOutput("ovfA", 32'(ifA.ovf), 32'(ovfA));
    checkOutput("ovfB", 32'(ifB.ovf), 32'(ovfB));
`endif

    repeat ($urandom_range(0, 3)) begin
      @(posedge clk); #1;
    end
    checkOutput("validA_hold", 32'(ifA.result_valid), 32'd1);
    checkOutput("resultB_hold", 32'(ifB.result), 32'(sumB));

    resultAck = 1'b1; start = ackWithStart;
    @(posedge clk); #1;
    resultAck = 1'b0; start = 1'b0;
    checkOutput("resultA_kept", 32'(ifA.result), 32'(sumA));
    checkOutput("resultB_kept", 32'(ifB.result), 32'(sumB));
`ifdef SIGNED_OVF_EN
    checkOutput("ovfA_kept", 32'(ifA.ovf), 32'(ovfA));
`endif
    checkIdle("ack");
    @(posedge clk); #1;
    checkIdle("postAck");
  endtask

  initial begin
    start = 1'b0; cInReq = 1'b0; serIn = 1'b0; serValid = 1'b0; resultAck = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    checkIdle("reset");
    checkOutput("reset_xA", 32'(ifA.x), 32'd0);
    checkOutput("reset_yB", 32'(ifB.y), 32'd0);
    checkOutput("reset_resA", 32'(ifA.result), 32'd0);
    checkOutput("reset_cinB", 32'(ifB.c_in), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases (arrival order, bit 0 first on the wire).
    applyStimulus(1'b0, 4'b0101, 4'b0011, 1'b0, 1'b0); // A: 5+3
    applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0); // 15+15+1
    applyStimulus(1'b1, 4'b1001, 4'b0110, 1'b1, 1'b0); // A: 9+6+1 with stalls
    applyStimulus(1'b0, 4'b1110, 4'b1000, 1'b0, 1'b0); // B: 0111+0001
    applyStimulus(1'b0, 4'b0011, 4'b0101, 1'b0, 1'b1); // start together with ack
    applyStimulus(1'b1, 4'b1010, 4'b0001, 1'b1, 1'b0); // fresh start afterwards

    for (int n = 0; n < 20; n++) begin
      applyStimulus(1'($urandom), 4'($urandom), 4'($urandom),
                    1'($urandom), 1'($urandom));
    end

    // Reset in the middle of loading y aborts both instances.
    @(posedge clk); #1;
    start = 1'b1; cInReq = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      serValid = 1'b1; serIn = 1'($urandom);
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    checkIdle("midReset");
    checkOutput("midReset_xA", 32'(ifA.x), 32'd0);
    checkOutput("midReset_xB", 32'(ifB.x), 32'd0);
    checkOutput("midReset_cinA", 32'(ifA.c_in), 32'd0);
    checkOutput("midReset_resB", 32'(ifB.result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      serValid = 1'b1; serIn = 1'($urandom);
      @(posedge clk); #1;
    end
    serValid = 1'b0;
    checkIdle("afterReset");

    applyStimulus(1'b0, 4'b0110, 4'b1101, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
